rr_arb_mux: RTL

- Parametrised N-way, WIDTH-bit registered multiplexer with round-robin arbitration and valid/ready handshakes on every input and on the output.
- Successor to the datapath 2:1 select: the select is generated internally and fairly, not driven by control.
- Sits in front of shared resources: one memory port serving fetch and load/store, and the writeback bus serving multiple producers.
- One output register stage; full throughput.

---
 rtl/rr_arb_mux_pkg.sv | 8 +
 rtl/rr_arb_mux_if.sv | 23 ++
 rtl/rr_arb_pick.sv | 22 ++
 rtl/rr_arb_mux.sv | 44 ++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared index-width derivation and reset constants for the round-robin mux
package rr_arb_mux_pkg;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int PTR_RST = 0;
  localparam logic DATA_RST = 1'b0;
endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: per-channel request bundle plus registered output handshake
interface rr_arb_mux_if import rr_arb_mux_pkg::*; #(
  parameter int N = 2,
  parameter int WIDTH = 32
) ();
  localparam int SELW = sel_w(N);
  logic [N-1:0] in_valid;
  logic [N-1:0] in_lock;
  logic [N-1:0] in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_sel;
  modport master (
    output in_valid, in_data, in_lock, out_ready,
    input in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input in_valid, in_data, in_lock, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin pick of the first requester at or after ptr
module rr_arb_pick import rr_arb_mux_pkg::*; #(
  parameter int N = 2,
  localparam int SELW = sel_w(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            any_req
);
  logic [N-1:0] upper, req;
  // Requests at or above ptr win; otherwise wrap around to the lowest requester.
  assign upper = valid & ~((N'(1) << ptr) - N'(1));
  assign req = |upper ? upper : valid;
  assign grant = req & (~req + N'(1));
  assign any_req = |valid;
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = grant[i] ? SELW'(i) : idx;
  end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-way round-robin arbitrated mux with one registered output stage
module rr_arb_mux import rr_arb_mux_pkg::*; #(
  parameter int N = 2,
  parameter int WIDTH = 32,
  localparam int SELW = sel_w(N)
) (
  input logic clk,
  input logic rst,
  rr_arb_mux_if.slave bus
);
  logic [SELW-1:0] ptr, g, ptr_next;
  logic [N-1:0] gnt;
  logic any_req, xfer;
  logic [WIDTH-1:0] win;
  rr_arb_pick #(.N(N)) u_pick (
    .valid(bus.in_valid),
    .ptr(ptr),
    .grant(gnt),
    .idx(g),
    .any_req(any_req)
  );
  assign xfer = !rst && (!bus.out_valid || bus.out_ready) && any_req;
  assign bus.in_ready = xfer ? gnt : '0;
  assign ptr_next = |(bus.in_lock & gnt) ? g : (g == SELW'(N - 1)) ? SELW'(PTR_RST) : g + SELW'(1);
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) win = gnt[i] ? bus.in_data[i*WIDTH +: WIDTH] : win;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= {WIDTH{DATA_RST}};
      bus.out_sel <= SELW'(PTR_RST);
      ptr <= SELW'(PTR_RST);
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data <= win;
      bus.out_sel <= g;
      ptr <= ptr_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
